// File: rtl/encoder_16x4_ah.sv
// Registered 16-to-4 priority request encoder with sticky pending bits.
// Ports: clk, rst_n, E, D[0:15], ACK in; A[3:0], V, PEND[0:15], DROP out.
module encoder_16x4_ah (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        E,
    input  logic [0:15] D,
    input  logic        ACK,
    output logic [3:0]  A,
    output logic        V,
    output logic [0:15] PEND,
    output logic        DROP
);

    typedef enum logic {
        IDLE  = 1'b0,
        SERVE = 1'b1
    } state_t;

    state_t      state;
    state_t      state_nx;
    logic [3:0]  a_nx;
    logic [0:15] p;
    logic [0:15] set_v;
    logic [0:15] clr;
    logic [0:15] p_nx;
    logic        drop_nx;

    // Lowest index wins; D[0] is the highest priority line.
    function automatic logic [3:0] lowest(input logic [0:15] v);
        lowest = 4'd0;
        for (int k = 15; k >= 0; k--) begin
            if (v[k]) lowest = 4'(k);
        end
    endfunction

    always_comb begin
        set_v = E ? D : '0;
        clr = '0;
        clr[A] = (state == SERVE) & ACK;
        // Set beats clear so a request arriving with its own ack re-arms.
        p_nx = set_v | (p & ~clr);
        drop_nx = |(set_v & p & ~clr);
    end

    always_comb begin
        state_nx = state;
        a_nx = A;
        unique case (state)
            IDLE: begin
                if (|p) begin
                    a_nx = lowest(p);
                    state_nx = SERVE;
                end
            end
            SERVE: begin
                // A is frozen until ack; no preemption.
                if (ACK) begin
                    if (|p_nx) a_nx = lowest(p_nx);
                    else state_nx = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            A <= 4'd0;
            p <= '0;
            DROP <= 1'b0;
        end else begin
            state <= state_nx;
            A <= a_nx;
            p <= p_nx;
            DROP <= drop_nx;
        end
    end

    assign V = (state == SERVE);
    assign PEND = p;

endmodule

// File: doc/encoder_16x4_ah.md
# encoder_16x4_ah

Registered 16-to-4 priority request encoder, active-high, the inverse of the 4x16 decoder path. Each of the 16 request lines sets a sticky pending bit. The block presents the lowest-index pending request as a 4-bit code with a valid/acknowledge handshake, and clears that request on acknowledge. Its code output drives the 4x16 decoder's select input in the lab datapath, so the round trip D[k] -> A=k -> decoded D[k] closes.

## Interface
Parameters: none. Width is fixed at 16 requests / 4-bit code.

Clocking and reset (already decided): one clock; reset is asynchronous and active-low.

- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- E  input  1  capture enable, active-high; when 0, D is ignored
- D  input  [0:15]  request lines, active-high, one cycle per request; D[0] highest priority
- ACK  input  1  consumer accepts the current code; meaningful only while V=1
- A  output  [3:0]  encoded index of the presented request
- V  output  1  A is valid
- PEND  output  [0:15]  current pending-request register
- DROP  output  1  one-cycle pulse: an incoming request merged into an already-pending bit

## Operation
- Pending register P[0:15]:
  - set[k] = E & D[k].
  - clr[k] = V & ACK & (A == k).
  - P_next[k] = set[k] | (P[k] & ~clr[k]). Set wins over clear on the same bit in the same cycle, so the request re-arms.
- PEND = P, direct from the register.
- Output FSM, two states:
  - IDLE (V=0).
  - SERVE (V=1). The state register is V itself.
- IDLE:
  - If P != 0, load A = index of the lowest set bit of P, set V=1, go to SERVE.
  - Otherwise stay in IDLE; A holds its last value.
- SERVE, ACK=0:
  - Hold A and V stable.
  - Arrival of new, higher-priority requests does not change A. There is no preemption.
- SERVE, ACK=1. Let R = P & ~onehot(A) & ~... Define R = (P with bit A cleared) | set, matching P_next.
  - If R != 0: load A = lowest set index of R, keep V=1. This gives back-to-back service at one code per cycle.
  - If R == 0: V=0, go to IDLE; A holds.
- ACK while V=0 is ignored. It has no effect on P or on the FSM.
- DROP = registered (|(set & P & ~clr)). Bits whose pending request is being cleared that cycle do not count.
- Priority encode: lowest index wins, e.g. P = 0000_0000_0010_0100 (bits 10 and 13 set) -> A = 4'd10.

## Timing
- Reset values, applied asynchronously and immediately on rst_n=0, mid-operation included:
  - P = 0, PEND = 0, A = 4'd0, V = 0, DROP = 0.
  - All pending requests are discarded.
  - After deassertion, the first capture happens on the first rising edge with rst_n=1.
- Latency:
  - D[k] sampled high at edge n -> PEND[k]=1 after edge n.
  - If the FSM is idle, V=1 and A=k after edge n+1. That is 2 cycles from request to valid.
- Handshake:
  - The transfer occurs on an edge where V=1 and ACK=1.
  - PEND[A] clears after that same edge, unless it is re-set in that cycle.
  - Maximum throughput is one code per cycle while requests remain.
- While V=1 and ACK=0, A must not change on any edge.
- Simultaneous requests on several lines in one cycle are all captured. They are served in ascending index order over successive transfers.
- With E=0 held, no new requests are captured, but pending requests continue to be served to completion.
- DROP is asserted for exactly the cycle after the offending edge.
- There are no combinational paths from inputs to outputs. All outputs are registered.

## Test plan
- Reset mid-service:
  - Stimulus: pend bits 3 and 9, then assert rst_n=0 while V=1, with no clk edge.
  - Response: V, A, PEND, and DROP all go to 0 immediately. After release, with no new D, V stays 0.
- Single request:
  - Stimulus: E=1, D[7] pulsed 1 cycle, ACK held 0.
  - Response: PEND[7]=1 after 1 edge; V=1, A=7 after 2 edges. A and V are held for 10 cycles.
  - Then ACK=1 for 1 cycle -> V=0, PEND=0.
- Priority order:
  - Stimulus: in one cycle, D[0], D[5], D[15] = 1; ACK held 1.
  - Response: A sequence 0, 5, 15 on consecutive cycles with V=1, then V=0 and PEND=0.
- No preemption / enable:
  - Stimulus: serve A=12 with ACK=0; pulse D[2] with E=1, then D[1] with E=0.
  - Response: A stays 12 and PEND[2]=1, PEND[1]=0. After ACK -> A=2.
- Merge and re-arm:
  - Stimulus: D[4] pulsed twice while PEND[4]=1 and not acked.
  - Response: DROP pulses once per repeat; only one code 4 is served.
  - Stimulus: D[4] pulsed in the same cycle as ACK of A=4.
  - Response: no DROP; PEND[4] stays 1 and code 4 is served again.
- Round trip:
  - Stimulus: feed A into the 4x16 decoder with E=1, sweeping D[k] for k = 0..15.
  - Response: the decoder output equals the single asserted D[k] for every k.
